game_tick_gen: RTL and testbench

Parametrised multi-channel tick generator for the game logic, running directly off the 50 MHz board clock. Each channel owns a runtime-loadable down-counter that produces a one-cycle tick pulse and a square-wave game clock. A global pause, per-channel enables, a 2x fast-forward mode and a resynchronise command are also provided. Sits between CLOCK_50 and the game FSM, sprite movers and display refresh logic, as the successor to the single-rate game clock.

---
 rtl/game_tick_gen.sv | 116 +++++++++++
 tb/tb_game_tick_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/game_tick_gen.sv
// rtl/game_tick_gen.sv - multi-channel programmable game tick / game clock generator
// Early clock compare logic is built only when GAME_TICK_EARLY_EN is defined.
module game_tick_gen #(
   parameter int N_CH      = 4,
   parameter int CNT_W     = 28,
   parameter int DIV_RESET = 4111392,
   parameter int EARLY_OFF = 127
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [N_CH-1:0]  CH_EN,
   input  logic             FAST,
   input  logic             SYNC,
   input  logic             DIV_WE,
   input  logic [2:0]       DIV_SEL,
   input  logic [CNT_W-1:0] DIV_DATA,
   output logic [N_CH-1:0]  NEW_PULSE,
   output logic [N_CH-1:0]  NEW_CLOCK,
   output logic [N_CH-1:0]  NEW_CLOCK_EARLY,
   output logic [15:0]      FRAME_CNT
);

   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

   logic [CNT_W-1:0] div     [N_CH];
   logic [CNT_W-1:0] cnt     [N_CH];
   logic [CNT_W-1:0] cnt_dec [N_CH];
   logic [N_CH-1:0]  active;
   logic [N_CH-1:0]  wrap;

   // Fast-forward decrement saturates so a count of 1 lands on 0 instead of wrapping.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         active[i] = ENABLE & CH_EN[i];
         wrap[i]   = active[i] & (cnt[i] == '0);
         if (FAST)
            cnt_dec[i] = (cnt[i] == CNT_W'(1)) ? '0 : cnt[i] - CNT_W'(2);
         else
            cnt_dec[i] = cnt[i] - CNT_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < N_CH; i++)
            div[i] <= DIV_INIT;
      end else if (DIV_WE) begin
         for (int i = 0; i < N_CH; i++)
            if (DIV_SEL == 3'(i))
               div[i] <= DIV_DATA;
      end
   end

   // Reload reads div before this edge's write lands, so a same-edge write waits a period.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < N_CH; i++)
            cnt[i] <= DIV_INIT;
         NEW_PULSE <= '0;
         NEW_CLOCK <= '0;
      end else if (SYNC) begin
         for (int i = 0; i < N_CH; i++)
            cnt[i] <= div[i];
         NEW_PULSE <= '0;
         NEW_CLOCK <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            NEW_PULSE[i] <= wrap[i];
            if (wrap[i]) begin
               cnt[i]       <= div[i];
               NEW_CLOCK[i] <= ~NEW_CLOCK[i];
            end else if (active[i]) begin
               cnt[i] <= cnt_dec[i];
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         FRAME_CNT <= '0;
      else if (SYNC)
         FRAME_CNT <= '0;
      else if (wrap[0])
         FRAME_CNT <= FRAME_CNT + 16'd1;
   end

`ifdef GAME_TICK_EARLY_EN
   localparam logic [CNT_W-1:0] EARLY_AT   = CNT_W'(EARLY_OFF);
   localparam logic [CNT_W-1:0] EARLY_FAST = CNT_W'(EARLY_OFF + 1);

   logic [N_CH-1:0] early_hit;

   // In fast mode the count may step over EARLY_AT, so the odd neighbour also fires.
   always_comb begin
      for (int i = 0; i < N_CH; i++)
         early_hit[i] = active[i] & (div[i] >= EARLY_AT) &
                        ((cnt[i] == EARLY_AT) | (FAST & (cnt[i] == EARLY_FAST)));
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         NEW_CLOCK_EARLY <= '0;
      else if (SYNC)
         NEW_CLOCK_EARLY <= '0;
      else
         NEW_CLOCK_EARLY <= NEW_CLOCK_EARLY ^ early_hit;
   end
`else
   localparam int unused_early_off = EARLY_OFF;

   assign NEW_CLOCK_EARLY = '0;
`endif

endmodule

// File: tb/tb_game_tick_gen.sv
// tb/tb_game_tick_gen.sv - directed table-driven bench for game_tick_gen
// Early clock checks switch with GAME_TICK_EARLY_EN.
module tb_game_tick_gen;

   logic        CLOCK_50 = 1'b0;
   logic        RESET;
   logic        ENABLE;
   logic [3:0]  CH_EN;
   logic        FAST;
   logic        SYNC;
   logic        DIV_WE;
   logic [2:0]  DIV_SEL;
   logic [27:0] DIV_DATA;
   logic [3:0]  NEW_PULSE;
   logic [3:0]  NEW_CLOCK;
   logic [3:0]  NEW_CLOCK_EARLY;
   logic [15:0] FRAME_CNT;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   game_tick_gen #(
      .N_CH(4), .CNT_W(28), .DIV_RESET(9), .EARLY_OFF(3)
   ) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .ENABLE(ENABLE), .CH_EN(CH_EN),
      .FAST(FAST), .SYNC(SYNC), .DIV_WE(DIV_WE), .DIV_SEL(DIV_SEL),
      .DIV_DATA(DIV_DATA), .NEW_PULSE(NEW_PULSE), .NEW_CLOCK(NEW_CLOCK),
      .NEW_CLOCK_EARLY(NEW_CLOCK_EARLY), .FRAME_CNT(FRAME_CNT)
   );

   typedef struct {
      int          n;
      logic        en;
      logic [3:0]  ch_en;
      logic        fast;
      logic        sync;
      logic        we;
      logic [2:0]  sel;
      logic [27:0] data;
      logic [3:0]  pulse;
      logic [3:0]  clock;
      logic [15:0] frame;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input logic en, input logic [3:0] ch_en,
                      input logic fast, input logic sync, input logic we,
                      input logic [2:0] sel, input logic [27:0] data,
                      input logic [3:0] pulse, input logic [3:0] clock,
                      input logic [15:0] frame);
      vec_t v;
      v.n = n; v.en = en; v.ch_en = ch_en; v.fast = fast; v.sync = sync;
      v.we = we; v.sel = sel; v.data = data;
      v.pulse = pulse; v.clock = clock; v.frame = frame;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int toggles;
      logic prev_early;

      // n  en ch_en fast sync we sel data  pulse clock frame (edges counted from reset release)
      add( 9, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // edge 9
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'hF, 16'd1); // 10 first tick
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'hF, 16'd1); // 11
      add( 9, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'h0, 16'd2); // 20
      add(30, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'hF, 16'd5); // 50
      add( 2, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'hF, 16'd5); // 52
      add( 1, 1, 4'hF, 0, 0, 1, 3'd1, 28'd4, 4'h0, 4'hF, 16'd5); // 53 write ch1 div=4
      add( 7, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'h0, 16'd6); // 60
      add( 5, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h2, 4'h2, 16'd6); // 65
      add( 5, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'hD, 16'd7); // 70
      add( 1, 1, 4'hF, 0, 0, 1, 3'd5, 28'd0, 4'h0, 4'hD, 16'd7); // 71 write sel=5 ignored
      add( 4, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h2, 4'hF, 16'd7); // 75
      add( 5, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'h0, 16'd8); // 80
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd8); // 81
      add( 1, 1, 4'hF, 0, 0, 1, 3'd1, 28'd9, 4'h0, 4'h0, 16'd8); // 82 ch1 div=9
      add( 1, 1, 4'hF, 0, 1, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 83 sync
      add( 5, 1, 4'hF, 1, 0, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 88 fast, cnt 1->0
      add( 1, 1, 4'hF, 1, 0, 0, 3'd0, 28'd0, 4'hF, 4'hF, 16'd1); // 89
      add( 6, 1, 4'hF, 1, 0, 0, 3'd0, 28'd0, 4'hF, 4'h0, 16'd2); // 95
      add( 1, 1, 4'hF, 0, 0, 1, 3'd0, 28'd0, 4'h0, 4'h0, 16'd2); // 96 ch0 div=0
      add( 1, 1, 4'hF, 0, 1, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 97 sync
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h1, 4'h1, 16'd1); // 98
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h1, 4'h0, 16'd2); // 99
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h1, 4'h1, 16'd3); // 100
      add( 1, 1, 4'hF, 0, 0, 1, 3'd0, 28'd9, 4'h1, 4'h0, 16'd4); // 101 write+reload: old div
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h1, 4'h1, 16'd5); // 102
      add( 1, 1, 4'hF, 0, 1, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 103 sync
      add( 5, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 108 cnt=4
      add( 7, 0, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 115 paused
      add( 4, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'h0, 16'd0); // 119
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hF, 4'hF, 16'd1); // 120 seven late
      add( 3, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'hF, 16'd1); // 123
      add( 3, 1, 4'hB, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'hF, 16'd1); // 126 ch2 held
      add( 3, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h0, 4'hF, 16'd1); // 129
      add( 1, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'hB, 4'h4, 16'd2); // 130
      add( 3, 1, 4'hF, 0, 0, 0, 3'd0, 28'd0, 4'h4, 4'h0, 16'd2); // 133 ch2 three late

      RESET = 1'b1; ENABLE = 1'b1; CH_EN = 4'hF; FAST = 1'b0; SYNC = 1'b0;
      DIV_WE = 1'b0; DIV_SEL = 3'd0; DIV_DATA = 28'd0;
      tick(3);
      chk("reset pulse", 32'(NEW_PULSE), 32'h0);
      chk("reset clock", 32'(NEW_CLOCK), 32'h0);
      chk("reset early", 32'(NEW_CLOCK_EARLY), 32'h0);
      chk("reset frame", 32'(FRAME_CNT), 32'h0);
      RESET = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         ENABLE = vecs[i].en; CH_EN = vecs[i].ch_en; FAST = vecs[i].fast;
         SYNC = vecs[i].sync; DIV_WE = vecs[i].we; DIV_SEL = vecs[i].sel;
         DIV_DATA = vecs[i].data;
         tick(vecs[i].n);
         chk($sformatf("v%0d pulse", i), 32'(NEW_PULSE), 32'(vecs[i].pulse));
         chk($sformatf("v%0d clock", i), 32'(NEW_CLOCK), 32'(vecs[i].clock));
         chk($sformatf("v%0d frame", i), 32'(FRAME_CNT), 32'(vecs[i].frame));
`ifndef GAME_TICK_EARLY_EN
         chk($sformatf("v%0d early", i), 32'(NEW_CLOCK_EARLY), 32'h0);
`endif
      end
      ENABLE = 1'b1; CH_EN = 4'hF; FAST = 1'b0; SYNC = 1'b0; DIV_WE = 1'b0;

      // Reset between edges must clear outputs before the next clock edge.
      #2 RESET = 1'b1;
      #1;
      chk("async reset pulse", 32'(NEW_PULSE), 32'h0);
      chk("async reset frame", 32'(FRAME_CNT), 32'h0);
      tick(2);
      RESET = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         chk($sformatf("post reset quiet e%0d", k), 32'(NEW_PULSE), 32'h0);
      end
      tick(1);
      chk("post reset first pulse", 32'(NEW_PULSE), 32'hF);
      chk("post reset first clock", 32'(NEW_CLOCK), 32'hF);
      chk("post reset frame", 32'(FRAME_CNT), 32'h1);

`ifdef GAME_TICK_EARLY_EN
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         tick(1);
         if (k == 6)  chk("early before toggle", 32'(NEW_CLOCK_EARLY[0]), 32'h0);
         if (k == 7)  chk("early toggles at cnt 3", 32'(NEW_CLOCK_EARLY[0]), 32'h1);
         if (k == 9)  chk("clock still low", 32'(NEW_CLOCK[0]), 32'h0);
         if (k == 10) chk("clock toggles", 32'(NEW_CLOCK[0]), 32'h1);
         if (k == 16) chk("early holds", 32'(NEW_CLOCK_EARLY[0]), 32'h1);
         if (k == 17) chk("early second toggle", 32'(NEW_CLOCK_EARLY[0]), 32'h0);
      end
      DIV_WE = 1'b1; DIV_SEL = 3'd0; DIV_DATA = 28'd2;
      tick(1);
      DIV_WE = 1'b0; SYNC = 1'b1;
      tick(1);
      SYNC = 1'b0;
      pulses = 0; toggles = 0; prev_early = NEW_CLOCK_EARLY[0];
      for (int k = 0; k < 20; k++) begin
         tick(1);
         if (NEW_PULSE[0]) pulses++;
         if (NEW_CLOCK_EARLY[0] != prev_early) toggles++;
         prev_early = NEW_CLOCK_EARLY[0];
      end
      chk("div2 pulse count", 32'(pulses), 32'd6);
      chk("div2 early toggles", 32'(toggles), 32'd0);
      chk("div2 early level", 32'(NEW_CLOCK_EARLY[0]), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
